// File: rtl/fir_coeff_loader.sv
// Purpose: validates I2C address byte and assembles big-endian 16-bit taps into a shadow bank, committed atomically on a well-formed stop.
// Latency: coeff_out/commit_out update on the first clk edge after the cycle in which stop_in is sampled high.
// Backpressure: none; bytes are accepted on every rising edge of valid_in and the loader cannot stall the i2c_slave.

package fir_filter_pkg;
  localparam int NTAPS = 4;
endpackage

module fir_coeff_loader #(
  parameter int         NTAPS = fir_filter_pkg::NTAPS,
  parameter logic [6:0] ADDR  = 7'h50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic                  valid_in,
  input  logic [7:0]            byte_in,
  output logic [NTAPS*16-1:0]   coeff_out,
  output logic                  commit_out,
  output logic                  err_out
);

  localparam int CW = $clog2(2*NTAPS+1);
  localparam logic [CW-1:0] FULL = CW'(2*NTAPS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NTAPS*16-1:0] shadow_q, shadow_d;
  logic [NTAPS*16-1:0] coeff_q, coeff_d;
  logic                commit_q, commit_d;
  logic                err_q, err_d;
  logic                valid_q;
  logic                byte_ev;
  logic [CW-1:0]       bidx;

  // valid_in is a level held for several cycles; only its rising edge counts as a byte
  assign byte_ev = valid_in & ~valid_q;

  // Next-state logic: the byte is consumed first, then stop is judged on the updated count
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    coeff_d  = coeff_q;
    commit_d = 1'b0;
    err_d    = err_q;
    // Even byte counts land in the high half of a tap, so flip bit 0 to get the vector byte slot
    bidx     = {cnt_q[CW-1:1], ~cnt_q[0]};

    if (start_in) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      if (byte_ev) begin
        case (state_q)
          S_ADDR: state_d = (byte_in == {ADDR, 1'b0}) ? S_DATA : S_IDLE;
          S_DATA: begin
            if (cnt_q < FULL) begin
              shadow_d[8*int'(bidx) +: 8] = byte_in;
              cnt_d = cnt_q + 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = S_DROP;
            end
          end
          default: ;
        endcase
      end
      if (stop_in) begin
        case (state_d)
          S_ADDR: state_d = S_IDLE;
          S_DATA: begin
            if (cnt_d == FULL) begin
              coeff_d  = shadow_d;
              commit_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = S_IDLE;
          end
          S_DROP: state_d = S_IDLE;
          default: ;
        endcase
      end
    end
  end

  // State registers with synchronous reset; reset also clears the active bank
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      coeff_q  <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      coeff_q  <= coeff_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      valid_q  <= valid_in;
    end
  end

  assign coeff_out  = coeff_q;
  assign commit_out = commit_q;
  assign err_out    = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Purpose: self-checking bench for fir_coeff_loader against a frame-level reference model.
// Latency: checks commit/coeff one cycle after the stop strobe has been sampled.
// Backpressure: n/a; stimulus drives the byte stream freely.

module tb_fir_coeff_loader;
  localparam int NT = fir_filter_pkg::NTAPS;
  localparam int W  = NT*16;
  localparam int ND = 2*NT;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_in, stop_in, valid_in;
  logic [7:0]   byte_in;
  logic [W-1:0] coeff_out;
  logic         commit_out, err_out;

  int errors = 0;
  int checks = 0;
  int commit_seen = 0;

  // Reference model: bytes received since the last start, judged as a whole frame
  logic [7:0]   fq[$];
  logic         in_frame = 1'b0;
  logic [W-1:0] coeff_m = '0;
  logic         err_m = 1'b0;
  int           commits_m = 0;

  fir_coeff_loader dut (
    .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in),
    .valid_in(valid_in), .byte_in(byte_in), .coeff_out(coeff_out),
    .commit_out(commit_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  // Count commit pulse cycles away from the active edge
  always @(negedge clk) if (commit_out === 1'b1) commit_seen++;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_coeff"},  coeff_out, coeff_m);
    check({tag, "_err"},    W'(err_out), W'(err_m));
    check({tag, "_commits"}, W'(commit_seen), W'(commits_m));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_start();
    in_frame = 1'b1;
    fq.delete();
    err_m = 1'b0;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (in_frame) begin
      fq.push_back(b);
      if (fq[0] == 8'hA0 && fq.size() > ND + 1) err_m = 1'b1;
    end
  endfunction

  function automatic void m_stop();
    if (in_frame && fq.size() > 0 && fq[0] == 8'hA0) begin
      if (fq.size() == ND + 1) begin
        for (int j = 0; j < ND; j++)
          coeff_m[16*(j/2) + ((j % 2 == 0) ? 8 : 0) +: 8] = fq[j+1];
        commits_m++;
      end else begin
        err_m = 1'b1;
      end
    end
    in_frame = 1'b0;
    fq.delete();
  endfunction

  task automatic send_start();
    start_in = 1'b1; step(); start_in = 1'b0;
    m_start();
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    byte_in = b; valid_in = 1'b1;
    repeat (hold) step();
    valid_in = 1'b0;
    step(); step();
    m_byte(b);
  endtask

  task automatic send_stop();
    stop_in = 1'b1; step(); stop_in = 1'b0; step();
    m_stop();
  endtask

  // Last data byte arrives in the same cycle as the stop strobe
  task automatic send_byte_stop(input logic [7:0] b);
    byte_in = b; valid_in = 1'b1; stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    step();
    valid_in = 1'b0;
    step();
    m_byte(b);
    m_stop();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    coeff_m = '0; err_m = 1'b0; in_frame = 1'b0; fq.delete();
  endtask

  initial begin
    rst = 1'b1; start_in = 1'b0; stop_in = 1'b0; valid_in = 1'b0; byte_in = 8'h00;
    do_reset();
    check("reset_commit", W'(commit_out), '0);
    check_all("reset");

    // Nominal frame
    send_start(); send_byte(8'hA0, 2);
    for (int i = 1; i <= ND; i++) send_byte(8'(i), 1 + $urandom_range(0, 3));
    send_stop();
    check("nominal_value", coeff_out, W'(64'h0708_0506_0304_0102));
    check_all("nominal");

    // Short frame
    send_start(); send_byte(8'hA0, 2);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 2);
    send_stop();
    check_all("short");
    step(); step();
    check("short_err_sticky", W'(err_out), W'(1));

    // Foreign write address, then read-bit address
    send_start();
    check("start_clears_err", W'(err_out), '0);
    send_byte(8'hA2, 3);
    for (int i = 0; i < ND; i++) send_byte(8'($urandom), 2);
    send_stop();
    check_all("foreign");
    send_start(); send_byte(8'hA1, 3);
    for (int i = 0; i < ND; i++) send_byte(8'($urandom), 2);
    send_stop();
    check_all("readbit");

    // Overlength: error visible right after the extra byte, before stop
    send_start(); send_byte(8'hA0, 2);
    for (int i = 0; i < ND; i++) send_byte(8'($urandom), 2);
    check("over_before", W'(err_out), '0);
    send_byte(8'h5A, 2);
    check("over_on_byte", W'(err_out), W'(1));
    send_stop();
    check_all("over");

    // Repeated start mid-frame, then full frame of 0xFF
    send_start(); send_byte(8'hA0, 2);
    for (int i = 0; i < 3; i++) send_byte(8'h11, 2);
    send_start(); send_byte(8'hA0, 2);
    for (int i = 0; i < ND; i++) send_byte(8'hFF, 2);
    send_stop();
    check("restart_ones", coeff_out, '1);
    check_all("restart");

    // Reset mid-frame after a commit; subsequent stop must not commit
    send_start(); send_byte(8'hA0, 2);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 2);
    do_reset();
    check("midreset_coeff", coeff_out, '0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 2);
    send_stop();
    check_all("midreset");

    // Long valid_in hold: each byte counted once
    send_start(); send_byte(8'hA0, 10);
    for (int i = 0; i < ND; i++) send_byte(8'($urandom), 10);
    send_stop();
    check_all("longhold");

    // Final byte coincident with stop
    send_start(); send_byte(8'hA0, 2);
    for (int i = 0; i < ND - 1; i++) send_byte(8'($urandom), 2);
    send_byte_stop(8'($urandom));
    check_all("byte_stop");

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      int n;
      int sel;
      send_start();
      sel = int'($urandom_range(0, 9));
      n   = int'($urandom_range(0, ND + 2));
      if (sel != 9) begin
        send_byte((sel < 7) ? 8'hA0 : ((sel == 7) ? 8'hA1 : 8'($urandom)), 1 + $urandom_range(0, 4));
        if (sel == 0 && n > 1) begin
          for (int i = 0; i < n / 2; i++) send_byte(8'($urandom), 2);
          send_start();
          send_byte(8'hA0, 2);
        end
        if (sel == 1) n = ND;
        for (int i = 0; i < n; i++) send_byte(8'($urandom), 1 + $urandom_range(0, 4));
      end
      send_stop();
      check_all("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
